// File: rtl/bsg_manycore_link_rr_arb_pkg.sv
// Shared constants for the manycore link round-robin arbiter: mesh direction
// indices and a modular index helper used by the rotating priority search.
package bsg_manycore_link_rr_arb_pkg;

    typedef enum logic [2:0] {
        DirP = 3'd0,
        DirW = 3'd1,
        DirE = 3'd2,
        DirN = 3'd3,
        DirS = 3'd4
    } dir_e;

    localparam int unsigned NumDirs = 5;

    function automatic int unsigned wrap_idx(int unsigned base, int unsigned offset,
                                             int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/bsg_manycore_link_rr_arb_if.sv
// Requester-side and downstream-side handshake bundle of the link arbiter.
interface bsg_manycore_link_rr_arb_if
    import bsg_manycore_link_rr_arb_pkg::*;
#(
    parameter int unsigned num_in_p          = NumDirs,
    parameter int unsigned width_p           = 32,
    parameter int unsigned stall_cnt_width_p = 16
);
    logic [num_in_p-1:0]          v_i;
    logic [num_in_p*width_p-1:0]  data_i;
    logic [num_in_p-1:0]          yumi_o;
    logic                         v_o;
    logic [width_p-1:0]           data_o;
    logic                         ready_i;
    logic [stall_cnt_width_p-1:0] stall_cnt_o;

    modport master (
        output v_i, data_i, ready_i,
        input  yumi_o, v_o, data_o, stall_cnt_o
    );

    modport slave (
        input  v_i, data_i, ready_i,
        output yumi_o, v_o, data_o, stall_cnt_o
    );
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with ready/valid enqueue and valid/yumi dequeue; ready_o is
// simply "not full".
module bsg_two_fifo #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         cnt_r;
    logic               enq;

    assign ready_o = (cnt_r != 2'd2);
    assign v_o     = (cnt_r != 2'd0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (yumi_i) rd_ptr_r <= ~rd_ptr_r;
            case ({enq, yumi_i})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by cnt_r.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_link_rr_arb.sv
// Round-robin arbiter sharing one manycore link output among num_in_p
// requesters, with a two-entry output buffer and a saturating stall counter.
module bsg_manycore_link_rr_arb
    import bsg_manycore_link_rr_arb_pkg::*;
#(
    parameter int unsigned num_in_p          = NumDirs,
    parameter int unsigned width_p           = 32,
    parameter int unsigned stall_cnt_width_p = 16,
    localparam int unsigned ptr_w            = $clog2(num_in_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_manycore_link_rr_arb_if.slave   link
);
    logic [ptr_w-1:0]             last_r;
    logic [num_in_p-1:0]          rot_v;
    logic                         found;
    logic [ptr_w-1:0]             rot_idx;
    logic [ptr_w-1:0]             win_idx;
    logic                         grant;
    logic                         fifo_ready;
    logic                         fifo_v;
    logic                         deq;
    logic [width_p-1:0]           enq_data;
    logic [stall_cnt_width_p-1:0] stall_cnt_r;

    // Rotate so that position 0 is the requester just after the last winner.
    always_comb begin
        rot_v = '0;
        for (int unsigned i = 0; i < num_in_p; i++) begin
            rot_v[i] = link.v_i[ptr_w'(wrap_idx(32'(last_r), i + 1, num_in_p))];
        end
    end

    always_comb begin
        found   = 1'b0;
        rot_idx = '0;
        for (int i = int'(num_in_p) - 1; i >= 0; i--) begin
            if (rot_v[i]) begin
                found   = 1'b1;
                rot_idx = ptr_w'(i);
            end
        end
    end

    assign win_idx  = ptr_w'(wrap_idx(32'(last_r), 32'(rot_idx) + 1, num_in_p));
    // Eligibility uses only the buffer count, never ready_i.
    assign grant    = found & fifo_ready & ~reset_i;
    assign enq_data = link.data_i[32'(win_idx)*width_p +: width_p];

    always_comb begin
        link.yumi_o = '0;
        if (grant) link.yumi_o[win_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_r <= ptr_w'(num_in_p - 1);
        end else if (grant) begin
            last_r <= win_idx;
        end
    end

    assign deq = fifo_v & link.ready_i;

    bsg_two_fifo #(
        .width_p (width_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (fifo_ready),
        .data_i  (enq_data),
        .v_i     (grant),
        .v_o     (fifo_v),
        .data_o  (link.data_o),
        .yumi_i  (deq)
    );

    assign link.v_o = fifo_v;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_r <= '0;
        end else if (fifo_v && !link.ready_i && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + 1'b1;
        end
    end

    assign link.stall_cnt_o = stall_cnt_r;

endmodule
